// File: rtl/cond_sum_pkg.sv
// cond_sum_pkg: shared types and helpers for the pipelined conditional-sum adder
package cond_sum_pkg;
  localparam int MAX_WIDTH = 64;
  typedef struct packed {
    logic s0;
    logic s1;
    logic c0;
    logic c1;
  } cs_pair_t;
  function automatic logic width_ok(input int w);
    return w >= 4 && w <= MAX_WIDTH && (w & (w - 1)) == 0;
  endfunction
  // sum/carry of one bit position for an assumed carry-in of 0 and of 1
  function automatic cs_pair_t bit_pair(input logic a, input logic b);
    return '{s0: a ^ b, s1: ~(a ^ b), c0: a & b, c1: a | b};
  endfunction
endpackage

// File: rtl/cond_sum_merge.sv
// cond_sum_merge: joins two BLK-wide conditional blocks into one 2*BLK-wide block
module cond_sum_merge #(
  parameter int BLK = 1
) (
  input  logic [BLK-1:0]   lo_s0_i,
  input  logic [BLK-1:0]   lo_s1_i,
  input  logic             lo_c0_i,
  input  logic             lo_c1_i,
  input  logic [BLK-1:0]   hi_s0_i,
  input  logic [BLK-1:0]   hi_s1_i,
  input  logic             hi_c0_i,
  input  logic             hi_c1_i,
  output logic [2*BLK-1:0] s0_o,
  output logic [2*BLK-1:0] s1_o,
  output logic             c0_o,
  output logic             c1_o
);
  assign s0_o = {lo_c0_i ? hi_s1_i : hi_s0_i, lo_s0_i};
  assign s1_o = {lo_c1_i ? hi_s1_i : hi_s0_i, lo_s1_i};
  assign c0_o = lo_c0_i ? hi_c1_i : hi_c0_i;
  assign c1_o = lo_c1_i ? hi_c1_i : hi_c0_i;
endmodule

// File: rtl/cond_sum_adder_pipe.sv
// cond_sum_adder_pipe: pipelined conditional-sum add/sub, one register per merge level,
// valid/ready handshake with a global stall.
module cond_sum_adder_pipe
  import cond_sum_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int LEVELS = $clog2(WIDTH);
  localparam int NC = 2 * WIDTH - 1;
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("cond_sum_adder_pipe: WIDTH must be a power of two in 4..%0d", MAX_WIDTH);
  end
  // block carries of all levels packed back to back; level k holds WIDTH>>k of them
  function automatic int coff(input int k);
    return 2 * WIDTH - 2 * (WIDTH >> k);
  endfunction
  logic [(LEVELS+1)*WIDTH-1:0] s0_q, s1_q, s0_d, s1_d;
  logic [NC-1:0]               c0_q, c1_q, c0_d, c1_d;
  logic [LEVELS:0]             vld_q, vld_d, am_q, am_d, bm_q, bm_d;
  logic [WIDTH-1:0]            bx;
  logic                        cx, stall, unused_final;
  assign bx = Sub ? ~B : B;
  assign cx = Sub | Cin;
  assign stall = vld_q[LEVELS] & ~out_ready;
  assign in_ready = ~stall;
  assign vld_d = {vld_q[LEVELS-1:0], in_valid};
  assign am_d = {am_q[LEVELS-1:0], A[WIDTH-1]};
  assign bm_d = {bm_q[LEVELS-1:0], bx[WIDTH-1]};
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cs_pair_t p;
    assign p = bit_pair(A[i], bx[i]);
    if (i == 0) begin : g_lsb
      assign {s0_d[0], s1_d[0], c0_d[0], c1_d[0]} = cx ? {p.s1, p.s1, p.c1, p.c1} : {p.s0, p.s0, p.c0, p.c0};
    end else begin : g_up
      assign {s0_d[i], s1_d[i], c0_d[i], c1_d[i]} = {p.s0, p.s1, p.c0, p.c1};
    end
  end
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int BLK = 1 << (k - 1);
    localparam int CI = coff(k - 1);
    localparam int CO = coff(k);
    for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_blk
      cond_sum_merge #(.BLK(BLK)) u_merge (
        .lo_s0_i(s0_q[(k-1)*WIDTH + 2*j*BLK +: BLK]),
        .lo_s1_i(s1_q[(k-1)*WIDTH + 2*j*BLK +: BLK]),
        .lo_c0_i(c0_q[CI + 2*j]),
        .lo_c1_i(c1_q[CI + 2*j]),
        .hi_s0_i(s0_q[(k-1)*WIDTH + (2*j+1)*BLK +: BLK]),
        .hi_s1_i(s1_q[(k-1)*WIDTH + (2*j+1)*BLK +: BLK]),
        .hi_c0_i(c0_q[CI + 2*j + 1]),
        .hi_c1_i(c1_q[CI + 2*j + 1]),
        .s0_o(s0_d[k*WIDTH + 2*j*BLK +: 2*BLK]),
        .s1_o(s1_d[k*WIDTH + 2*j*BLK +: 2*BLK]),
        .c0_o(c0_d[CO + j]),
        .c1_o(c1_d[CO + j])
      );
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q  <= '0;
      s1_q  <= '0;
      c0_q  <= '0;
      c1_q  <= '0;
      vld_q <= '0;
      am_q  <= '0;
      bm_q  <= '0;
    end else if (!stall) begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      c0_q  <= c0_d;
      c1_q  <= c1_d;
      vld_q <= vld_d;
      am_q  <= am_d;
      bm_q  <= bm_d;
    end
  end
  // the final block is fully resolved, so its carry-1 copy carries no information
  assign unused_final = ^{s1_q[(LEVELS+1)*WIDTH-1 -: WIDTH], c1_q[NC-1]};
  assign Sum = s0_q[LEVELS*WIDTH +: WIDTH];
  assign Cout = c0_q[NC-1];
  assign Ovf = (am_q[LEVELS] == bm_q[LEVELS]) && (Sum[WIDTH-1] != am_q[LEVELS]);
  assign out_valid = vld_q[LEVELS];
endmodule

// File: tb/tb_cond_sum_adder_pipe.sv
// tb_cond_sum_adder_pipe: scoreboard bench driving a 16-bit and an 8-bit build side by side
module tb_cond_sum_adder_pipe;
  typedef struct {
    logic [63:0] sum;
    logic        co;
    logic        ov;
    int          cyc;
  } exp_t;
  logic        clk, rst_n, Cin, Sub, in_valid, out_ready;
  logic [15:0] A, B, sum16;
  logic [7:0]  sum8;
  logic        rdy16, co16, ov16, vld16, rdy8, co8, ov8, vld8;
  logic        rdy16_s, rdy8_s, acc16_s, chk_lat;
  int          checks, failures, cyc, idx;
  exp_t        q16[$], q8[$];
  cond_sum_adder_pipe #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .Cin(Cin), .Sub(Sub),
    .in_valid(in_valid), .in_ready(rdy16), .Sum(sum16), .Cout(co16), .Ovf(ov16),
    .out_valid(vld16), .out_ready(out_ready)
  );
  cond_sum_adder_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .A(A[7:0]), .B(B[7:0]), .Cin(Cin), .Sub(Sub),
    .in_valid(in_valid), .in_ready(rdy8), .Sum(sum8), .Cout(co8), .Ovf(ov8),
    .out_valid(vld8), .out_ready(out_ready)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic exp_t model(input int w);
    exp_t        e;
    logic [63:0] m, bx;
    logic [64:0] r;
    m = (64'd1 << w) - 64'd1;
    bx = (Sub ? ~{48'd0, B} : {48'd0, B}) & m;
    r = {1'b0, {48'd0, A} & m} + {1'b0, bx} + {64'd0, Sub | Cin};
    e.sum = r[63:0] & m;
    e.co = r[w];
    e.ov = (A[w-1] == bx[w-1]) && (e.sum[w-1] != A[w-1]);
    e.cyc = cyc;
    return e;
  endfunction
  // called just after a falling edge; samples half a cycle before the next rising edge
  task automatic step();
    exp_t e;
    #1;
    rdy16_s = rdy16;
    rdy8_s = rdy8;
    acc16_s = in_valid && rdy16;
    if (in_valid && rdy16) q16.push_back(model(16));
    if (in_valid && rdy8) q8.push_back(model(8));
    if (vld16) begin
      if (q16.size() == 0) check("unexpected16", vld16, 1'b0);
      else begin
        e = q16[0];
        check("sum16", {48'd0, sum16}, e.sum);
        check("cout16", co16, e.co);
        check("ovf16", ov16, e.ov);
        if (out_ready) begin
          void'(q16.pop_front());
          if (chk_lat) check("latency16", cyc - e.cyc, 5);
        end
      end
    end
    if (vld8) begin
      if (q8.size() == 0) check("unexpected8", vld8, 1'b0);
      else begin
        e = q8[0];
        check("sum8", {56'd0, sum8}, e.sum);
        check("cout8", co8, e.co);
        check("ovf8", ov8, e.ov);
        if (out_ready) begin
          void'(q8.pop_front());
          if (chk_lat) check("latency8", cyc - e.cyc, 4);
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask
  task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic c, input logic s);
    A = a;
    B = b;
    Cin = c;
    Sub = s;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 30 && (q16.size() != 0 || q8.size() != 0); i++) step();
    check("drain16", q16.size(), 0);
    check("drain8", q8.size(), 0);
  endtask
  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    chk_lat = 1'b0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    A = '0;
    B = '0;
    Cin = 1'b0;
    Sub = 1'b0;
    @(negedge clk);
    check("rst_valid16", vld16, 1'b0);
    check("rst_sum16", sum16, 16'h0);
    check("rst_valid8", vld8, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready16", rdy16, 1'b1);
    check("rst_ready8", rdy8, 1'b1);
    @(negedge clk);
    chk_lat = 1'b1;
    beat(16'h000F, 16'h0001, 1'b0, 1'b0);
    drain();
    chk_lat = 1'b0;
    beat(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    beat(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    beat(16'h8000, 16'h0001, 1'b0, 1'b1);
    beat(16'h1234, 16'h1234, 1'b0, 1'b1);
    beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    beat(16'h00F0, 16'h000F, 1'b0, 1'b0);
    beat(16'h0000, 16'h00FF, 1'b1, 1'b0);
    beat(16'h8000, 16'h8000, 1'b1, 1'b0);
    drain();
    // back-to-back stream with out_ready dropped for three cycles
    idx = 0;
    A = 16'($urandom);
    B = 16'($urandom);
    Cin = 1'($urandom);
    Sub = 1'($urandom);
    for (int t = 0; t < 20; t++) begin
      out_ready = !(t >= 6 && t <= 8);
      in_valid = idx < 8;
      step();
      check("in_ready16", rdy16_s, !(t >= 6 && t <= 8));
      check("in_ready8", rdy8_s, !(t >= 6 && t <= 8));
      if (acc16_s) begin
        idx++;
        A = 16'($urandom);
        B = 16'($urandom);
        Cin = 1'($urandom);
        Sub = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_beats", idx, 8);
    drain();
    // reset with beats still in flight
    beat(16'h1111, 16'h2222, 1'b0, 1'b0);
    beat(16'h3333, 16'h4444, 1'b1, 1'b0);
    beat(16'h5555, 16'h0101, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid16", vld16, 1'b0);
    check("midrst_sum16", sum16, 16'h0);
    check("midrst_valid8", vld8, 1'b0);
    check("midrst_sum8", sum8, 8'h0);
    q16.delete();
    q8.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step();
    chk_lat = 1'b1;
    beat(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    drain();
    chk_lat = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
